// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-bus arbiter: packet type, bus field widths, FSM states.
package mem_bus_pkg;

    localparam int BUS_NUM_REQ = 4;
    localparam int BUS_ADDR_W  = 64;
    localparam int BUS_DATA_W  = 64;
    localparam int BUS_SRC_W   = $clog2(BUS_NUM_REQ);

    // Encodings 2'b10 and 2'b11 are undefined; the arbiter flags them as errors.
    typedef enum logic [1:0] {
        bus_read_data  = 2'b00,
        bus_write_data = 2'b01
    } bus_packet_type_t;

    typedef logic [BUS_DATA_W-1:0] bus_packet_payload_t;
    typedef logic [BUS_ADDR_W-1:0] bus_address_t;
    typedef logic [BUS_SRC_W-1:0]  bus_source_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant
);

    int               w_idx;
    logic [IDX_W-1:0] w_idx_bits;

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        w_idx       = 0;
        w_idx_bits  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx      = (int'(rr_ptr) + k) % NUM_REQ;
            w_idx_bits = IDX_W'(w_idx);
            if (req[w_idx_bits]) begin
                grant_valid = 1'b1;
                grant       = w_idx_bits;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter in front of DRAM: one packet in flight, read data routed back by source ID.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a request; grant and req_ready are combinational
// ISSUE     | captured packet presented to DRAM until mem_req_ready
// WAIT_RESP | read issued; waiting for a response with our source ID
// RESP      | one-cycle rsp_valid strobe to the originating port
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ = BUS_NUM_REQ,
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int SRC_W   = BUS_SRC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*2-1:0]  req_type,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_payload,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [1:0]            mem_req_type,
    output logic [ADDR_W-1:0]     mem_req_address,
    output logic [DATA_W-1:0]     mem_req_payload,
    output logic [SRC_W-1:0]      mem_req_source,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_payload,
    input  logic [SRC_W-1:0]      mem_resp_source,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]     rsp_payload,
    output logic                  busy,
    output logic                  err_resp
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [SRC_W-1:0]  r_rr_ptr;
    logic [SRC_W-1:0]  r_src;
    logic [1:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_err;

    logic              w_grant_valid;
    logic [SRC_W-1:0]  w_grant;
    logic              w_accept;
    logic              w_rsp_load;
    logic              w_err_set;
    logic              w_type_known;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .rr_ptr      (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant       (w_grant)
    );

    assign w_type_known    = (r_type == bus_read_data) || (r_type == bus_write_data);
    assign mem_req_type    = r_type;
    assign mem_req_address = r_addr;
    assign mem_req_payload = r_wdata;
    assign mem_req_source  = r_src;
    assign rsp_payload     = r_rsp_data;
    assign err_resp        = r_err;
    assign busy            = (r_state != ST_IDLE);

    // Next-state, handshakes and error detection.
    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = '0;
        mem_req_valid = 1'b0;
        rsp_valid     = '0;
        w_accept      = 1'b0;
        w_rsp_load    = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_state_nxt        = ST_ISSUE;
                end
                if (mem_resp_valid) w_err_set = 1'b1;
            end
            ST_ISSUE: begin
                if (!w_type_known) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready)
                        w_state_nxt = (r_type == bus_write_data) ? ST_IDLE : ST_WAIT_RESP;
                end
                if (mem_resp_valid) w_err_set = 1'b1;
            end
            ST_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    if (mem_resp_source == r_src) begin
                        w_rsp_load  = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid[r_src] = 1'b1;
                w_state_nxt      = ST_IDLE;
                if (mem_resp_valid) w_err_set = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, round-robin pointer, captured packet, read data and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= SRC_W'(NUM_REQ - 1);
            r_src      <= '0;
            r_type     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_grant;
                r_src    <= w_grant;
                r_type   <= req_type[int'(w_grant)*2 +: 2];
                r_addr   <= req_address[int'(w_grant)*ADDR_W +: ADDR_W];
                r_wdata  <= req_payload[int'(w_grant)*DATA_W +: DATA_W];
            end
            if (w_rsp_load) r_rsp_data <= mem_resp_payload;
            if (w_err_set)  r_err      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs driven on the falling edge, outputs checked 1ns later.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int SRC_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*2-1:0]      req_type;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_payload;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [1:0]                mem_req_type;
    logic [ADDR_W-1:0]         mem_req_address;
    logic [DATA_W-1:0]         mem_req_payload;
    logic [SRC_W-1:0]          mem_req_source;
    logic                      mem_resp_valid;
    logic [DATA_W-1:0]         mem_resp_payload;
    logic [SRC_W-1:0]          mem_resp_source;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_payload;
    logic                      busy;
    logic                      err_resp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SRC_W   (SRC_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_type         (req_type),
        .req_address      (req_address),
        .req_payload      (req_payload),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_type     (mem_req_type),
        .mem_req_address  (mem_req_address),
        .mem_req_payload  (mem_req_payload),
        .mem_req_source   (mem_req_source),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_payload (mem_resp_payload),
        .mem_resp_source  (mem_resp_source),
        .rsp_valid        (rsp_valid),
        .rsp_payload      (rsp_payload),
        .busy             (busy),
        .err_resp         (err_resp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [1:0] t,
                            input logic [63:0] a, input logic [63:0] d);
        req_valid[p]                   = v;
        req_type[p*2 +: 2]             = t;
        req_address[p*ADDR_W +: ADDR_W] = a;
        req_payload[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset            = 1'b1;
        req_valid        = '0;
        req_type         = '0;
        req_address      = '0;
        req_payload      = '0;
        mem_req_ready    = 1'b0;
        mem_resp_valid   = 1'b0;
        mem_resp_payload = '0;
        mem_resp_source  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_order [6];
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset();
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_err", 64'(err_resp), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_payload", rsp_payload, 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);

        // single write from port 2, DRAM ready delayed 3 cycles
        @(negedge clk);
        set_port(2, 1'b1, bus_write_data, 64'h40, 64'h1122334455667788);
        #1;
        check_eq("t1_req_ready", 64'(req_ready), 64'b0100);
        check_eq("t1_mem_valid_early", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        set_port(2, 1'b0, bus_write_data, 64'h40, 64'h1122334455667788);
        #1;
        check_eq("t1_mem_valid", 64'(mem_req_valid), 64'd1);
        check_eq("t1_source", 64'(mem_req_source), 64'd2);
        check_eq("t1_type", 64'(mem_req_type), 64'(bus_write_data));
        check_eq("t1_addr", mem_req_address, 64'h40);
        check_eq("t1_payload", mem_req_payload, 64'h1122334455667788);
        check_eq("t1_ready_busy", 64'(req_ready), 64'd0);
        check_eq("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_eq("t1_hold_valid", 64'(mem_req_valid), 64'd1);
            check_eq("t1_hold_addr", mem_req_address, 64'h40);
            check_eq("t1_hold_payload", mem_req_payload, 64'h1122334455667788);
            check_eq("t1_hold_source", 64'(mem_req_source), 64'd2);
        end
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        check_eq("t1_hs_valid", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check_eq("t1_busy_after", 64'(busy), 64'd0);
        check_eq("t1_valid_after", 64'(mem_req_valid), 64'd0);

        // read from port 1, response 5 cycles later
        @(negedge clk);
        set_port(1, 1'b1, bus_read_data, 64'h80, 64'h0);
        #1;
        check_eq("t2_req_ready", 64'(req_ready), 64'b0010);
        @(negedge clk);
        set_port(1, 1'b0, bus_read_data, 64'h80, 64'h0);
        mem_req_ready = 1'b1;
        #1;
        check_eq("t2_mem_valid", 64'(mem_req_valid), 64'd1);
        check_eq("t2_type", 64'(mem_req_type), 64'(bus_read_data));
        check_eq("t2_source", 64'(mem_req_source), 64'd1);
        check_eq("t2_addr", mem_req_address, 64'h80);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            #1;
            check_eq("t2_wait_busy", 64'(busy), 64'd1);
            check_eq("t2_wait_rsp", 64'(rsp_valid), 64'd0);
            check_eq("t2_wait_memv", 64'(mem_req_valid), 64'd0);
        end
        @(negedge clk);
        mem_resp_valid   = 1'b1;
        mem_resp_payload = 64'hDEADBEEF00000001;
        mem_resp_source  = 2'd1;
        #1;
        check_eq("t2_rsp_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t2_rsp_valid", 64'(rsp_valid), 64'b0010);
        check_eq("t2_rsp_payload", rsp_payload, 64'hDEADBEEF00000001);
        @(negedge clk);
        #1;
        check_eq("t2_rsp_once", 64'(rsp_valid), 64'd0);
        check_eq("t2_payload_hold", rsp_payload, 64'hDEADBEEF00000001);
        check_eq("t2_busy_after", 64'(busy), 64'd0);
        check_eq("t2_err", 64'(err_resp), 64'd0);

        // fairness: all ports write continuously from reset
        do_reset();
        mem_req_ready = 1'b1;
        for (int p = 0; p < NUM_REQ; p++)
            set_port(p, 1'b1, bus_write_data, 64'(p) * 64'h100, 64'(p) + 64'hA0);
        for (int g = 0; g < 6; g++) begin
            #1;
            check_eq("t3_grant", 64'(req_ready), 64'(4'b0001 << exp_order[g]));
            @(negedge clk);
            #1;
            check_eq("t3_source", 64'(mem_req_source), 64'(exp_order[g]));
            check_eq("t3_addr", mem_req_address, 64'(exp_order[g]) * 64'h100);
            check_eq("t3_payload", mem_req_payload, 64'(exp_order[g]) + 64'hA0);
            @(negedge clk);
        end
        req_valid     = '0;
        mem_req_ready = 1'b0;
        #1;
        check_eq("t3_idle", 64'(busy), 64'd0);

        // read from port 3, wrong-source response first
        @(negedge clk);
        set_port(3, 1'b1, bus_read_data, 64'hC0, 64'h0);
        #1;
        check_eq("t4_req_ready", 64'(req_ready), 64'b1000);
        @(negedge clk);
        set_port(3, 1'b0, bus_read_data, 64'hC0, 64'h0);
        mem_req_ready = 1'b1;
        #1;
        check_eq("t4_source", 64'(mem_req_source), 64'd3);
        @(negedge clk);
        mem_req_ready    = 1'b0;
        mem_resp_valid   = 1'b1;
        mem_resp_source  = 2'd0;
        mem_resp_payload = 64'h1111111111111111;
        #1;
        check_eq("t4_err_before", 64'(err_resp), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t4_err_set", 64'(err_resp), 64'd1);
        check_eq("t4_still_busy", 64'(busy), 64'd1);
        check_eq("t4_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        mem_resp_valid   = 1'b1;
        mem_resp_source  = 2'd3;
        mem_resp_payload = 64'hA5A5A5A55A5A5A5A;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t4_rsp_valid", 64'(rsp_valid), 64'b1000);
        check_eq("t4_rsp_payload", rsp_payload, 64'hA5A5A5A55A5A5A5A);
        @(negedge clk);
        #1;
        check_eq("t4_rsp_once", 64'(rsp_valid), 64'd0);
        check_eq("t4_err_sticky", 64'(err_resp), 64'd1);

        // reset during WAIT_RESP, response arrives afterwards
        do_reset();
        set_port(0, 1'b1, bus_read_data, 64'h200, 64'h0);
        @(negedge clk);
        set_port(0, 1'b0, bus_read_data, 64'h200, 64'h0);
        mem_req_ready = 1'b1;
        #1;
        check_eq("t5_mem_valid", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        reset            = 1'b0;
        mem_resp_valid   = 1'b1;
        mem_resp_source  = 2'd0;
        mem_resp_payload = 64'h7777777777777777;
        #1;
        check_eq("t5_busy_reset", 64'(busy), 64'd0);
        check_eq("t5_err_reset", 64'(err_resp), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t5_err_late", 64'(err_resp), 64'd1);
        check_eq("t5_no_rsp", 64'(rsp_valid), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        check_eq("t5_no_rsp2", 64'(rsp_valid), 64'd0);
        check_eq("t5_payload_clr", rsp_payload, 64'd0);
        set_port(0, 1'b1, bus_read_data, 64'h208, 64'h0);
        #1;
        check_eq("t5b_req_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        set_port(0, 1'b0, bus_read_data, 64'h208, 64'h0);
        mem_req_ready = 1'b1;
        #1;
        check_eq("t5b_addr", mem_req_address, 64'h208);
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        mem_resp_valid   = 1'b1;
        mem_resp_source  = 2'd0;
        mem_resp_payload = 64'h0123456789ABCDEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t5b_rsp_valid", 64'(rsp_valid), 64'b0001);
        check_eq("t5b_rsp_payload", rsp_payload, 64'h0123456789ABCDEF);

        // unknown packet type dropped with error
        do_reset();
        set_port(0, 1'b1, 2'b11, 64'h300, 64'h55);
        #1;
        check_eq("t6_req_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        set_port(0, 1'b0, 2'b11, 64'h300, 64'h55);
        mem_req_ready = 1'b1;
        #1;
        check_eq("t6_no_mem_valid", 64'(mem_req_valid), 64'd0);
        check_eq("t6_busy_issue", 64'(busy), 64'd1);
        check_eq("t6_err_before", 64'(err_resp), 64'd0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check_eq("t6_idle", 64'(busy), 64'd0);
        check_eq("t6_err", 64'(err_resp), 64'd1);
        check_eq("t6_no_mem_valid2", 64'(mem_req_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly upstream of the DRAM model on the memory bus.
- Collects read/write packets from NUM_REQ cache/core ports, round-robin arbitrates, and forwards one packet at a time to DRAM.
- Holds one outstanding read and routes the DRAM read response back to the originating port by source ID.
- Single outstanding transaction; no reordering.

Parameters:
- NUM_REQ, 4: number of requester ports.
- ADDR_W, 64: packet address width (uint64_t).
- DATA_W, 64: payload width (8 bytes, PACK8 layout).
- SRC_W, 2: source ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-port request valid.
- req_ready  out  NUM_REQ  per-port accept; at most one bit high.
- req_type  in  NUM_REQ*2  per-port packet type (bus_packet_type_t).
- req_address  in  NUM_REQ*ADDR_W  per-port address.
- req_payload  in  NUM_REQ*DATA_W  per-port write data.
- mem_req_valid  out  1  packet to DRAM valid.
- mem_req_ready  in  1  DRAM accepts packet.
- mem_req_type  out  2  forwarded type.
- mem_req_address  out  ADDR_W  forwarded address.
- mem_req_payload  out  DATA_W  forwarded payload.
- mem_req_source  out  SRC_W  granted port index.
- mem_resp_valid  in  1  DRAM read response valid.
- mem_resp_payload  in  DATA_W  read data.
- mem_resp_source  in  SRC_W  response destination.
- rsp_valid  out  NUM_REQ  one-hot read-return strobe.
- rsp_payload  out  DATA_W  read data; shared by all ports.
- busy  out  1  high in any state other than IDLE.
- err_resp  out  1  sticky protocol-error flag.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, rr_ptr = NUM_REQ-1, captured packet cleared.
- Reset mid-operation aborts any pending packet or read. No response is delivered for an aborted read.
- States and transitions:
  - IDLE:
    - Grant = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
    - req_ready[grant] is asserted combinationally in the same cycle.
    - On handshake, capture type/address/payload/source, set rr_ptr = grant, go to ISSUE.
    - If no req_valid bit is set, stay in IDLE; rr_ptr is unchanged.
  - ISSUE:
    - mem_req_valid = 1 with the captured fields, held stable until mem_req_ready.
    - On mem_req_ready, a write returns to IDLE and a read goes to WAIT_RESP.
    - Unknown type (not bus_write_data or bus_read_data): set err_resp, drop the packet, go to IDLE without asserting mem_req_valid.
  - WAIT_RESP:
    - On mem_resp_valid with mem_resp_source == captured source: latch the payload, go to RESP.
    - On mem_resp_valid with any other source: set err_resp, ignore the response, remain in WAIT_RESP.
  - RESP: rsp_valid[source] = 1 for exactly one cycle, rsp_payload = latched data, then IDLE.
- Latency:
  - Request accepted in cycle t; mem_req_valid first high at t+1.
  - Response received at cycle r; rsp_valid high at r+1.
  - The next grant is possible in the cycle after RESP, or after the write handshake.
- mem_resp_valid in any state other than WAIT_RESP: set err_resp; the response is ignored.
- rsp_payload holds its last value when rsp_valid = 0.
- err_resp clears only on reset.
- req_ready is never asserted outside IDLE. Requesters must hold valid and fields stable until accepted.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 other grants.
- rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package mem_bus_pkg holds:
  - bus_packet_type_t (bus_read_data, bus_write_data);
  - bus_packet_payload_t (DATA_W), bus address and source-ID typedefs;
  - arbiter state enum.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and rr_ptr; outputs grant_valid and grant index. Purely combinational priority rotate; the pointer register lives in the parent.

Test Plan:
- Single write, port 2, addr 0x40, payload 0x1122334455667788: req_ready[2] same cycle, mem_req_valid next cycle with source=2. mem_req_ready delayed 3 cycles: fields stable throughout, busy drops after the handshake.
- Read from port 1, addr 0x80; DRAM answers 5 cycles later with payload 0xDEADBEEF00000001, source=1: rsp_valid = 4'b0010 for exactly one cycle, rsp_payload matches, no other rsp_valid bit set.
- All 4 ports request writes continuously from reset: grant order 0,1,2,3,0,1; no port is starved.
- Read from port 3, DRAM returns source=0 first, then source=3: err_resp set after the first response, state stays WAIT_RESP, rsp_valid[3] is delivered after the second.
- Reset asserted in WAIT_RESP, then the DRAM response arrives after reset: no rsp_valid, err_resp = 1 (response in IDLE), busy = 0. A subsequent port 0 read completes normally.
- Unknown req_type 2'b11 on port 0: accepted, mem_req_valid never asserted, err_resp = 1, back in IDLE two cycles after acceptance.
